// File: rtl/uart_tx.sv
// +--------------------------------------------------------------------------+
// | uart_tx : 8-bit UART transmitter, LSB first, 1 or 2 stop bits.           |
// | Optional parity bit when UART_TX_PARITY_EN is defined.                   |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx #(
  parameter int fclk       = 50_000_000,
  parameter int baud       = 115_200,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk50m,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx
);

  localparam int c_bit_clks = fclk / baud;
  localparam int c_cnt_w    = (c_bit_clks > 1) ? $clog2(c_bit_clks) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(c_bit_clks - 1);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);
  localparam bit c_two_stop = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , ST_PARITY = 3'd4
`endif
  } state_t;

  state_t             r_state, w_state_n;
  logic [c_cnt_w-1:0] r_width, w_width_n;
  logic [2:0]         r_bit_cnt, w_bit_cnt_n;
  logic [7:0]         r_shift, w_shift_n;
  logic               r_tx, w_tx_n;
  logic               r_done, w_done_n;
  logic               r_ready;
  logic               w_zero;

`ifdef UART_TX_PARITY_EN
  logic r_parity, w_parity_n;
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = PARITY_ODD;
`endif

  assign w_zero = (r_width == '0);

  always_comb begin
    w_state_n   = r_state;
    w_width_n   = r_width;
    w_bit_cnt_n = r_bit_cnt;
    w_shift_n   = r_shift;
    w_tx_n      = r_tx;
    w_done_n    = 1'b0;
`ifdef UART_TX_PARITY_EN
    w_parity_n  = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tx_n = 1'b1;
        if (tx_start) begin
          w_shift_n = tx_data;
`ifdef UART_TX_PARITY_EN
          w_parity_n = (^tx_data) ^ PARITY_ODD;
`endif
          w_width_n = c_reload;
          w_state_n = ST_START;
          w_tx_n    = 1'b0;
        end
      end
      ST_START: begin
        if (w_zero) begin
          w_width_n   = c_reload;
          w_bit_cnt_n = 3'd0;
          w_state_n   = ST_DATA;
          w_tx_n      = r_shift[0];
        end else begin
          w_width_n = r_width - c_one;
        end
      end
      ST_DATA: begin
        if (w_zero) begin
          w_shift_n   = {1'b0, r_shift[7:1]};
          w_width_n   = c_reload;
          w_bit_cnt_n = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_n = ST_PARITY;
            w_tx_n    = r_parity;
`else
            w_state_n = ST_STOP;
            w_tx_n    = 1'b1;
`endif
          end else begin
            w_tx_n = r_shift[1];
          end
        end else begin
          w_width_n = r_width - c_one;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_zero) begin
          w_width_n = c_reload;
          w_state_n = ST_STOP;
          w_tx_n    = 1'b1;
        end else begin
          w_width_n = r_width - c_one;
        end
      end
`endif
      ST_STOP: begin
        // The final stop cycle is spent in IDLE (tx high, ready, done), so a
        // start accepted there follows the stop bit with no idle gap.
        if (c_two_stop && (r_bit_cnt == 3'd0) && w_zero) begin
          w_width_n   = c_reload;
          w_bit_cnt_n = 3'd1;
        end else if ((!c_two_stop || (r_bit_cnt == 3'd1)) && (r_width == c_one)) begin
          w_width_n   = '0;
          w_bit_cnt_n = 3'd0;
          w_state_n   = ST_IDLE;
          w_done_n    = 1'b1;
          w_tx_n      = 1'b1;
        end else begin
          w_width_n = r_width - c_one;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_width   <= '0;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_width   <= w_width_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_shift   <= w_shift_n;
      r_tx      <= w_tx_n;
      r_done    <= w_done_n;
      r_ready   <= (w_state_n == ST_IDLE);
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_n;
`endif
    end
  end

  assign tx       = r_tx;
  assign tx_done  = r_done;
  assign tx_ready = r_ready;

endmodule

`default_nettype wire
